// File: rtl/vga_timing_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_gen_if
// Description : Signal bundle between the VGA timing generator, the colour
//               mapper that feeds it and the game logic that uses its frame tick.
// Revision    : 1.0 - initial release
// ============================================================================
interface vga_timing_gen_if;
   logic [7:0] Red_in;
   logic [7:0] Green_in;
   logic [7:0] Blue_in;
   logic [9:0] DrawX;
   logic [9:0] DrawY;
   logic       pixel_en;
   logic       vblank_start;
   logic [7:0] VGA_R;
   logic [7:0] VGA_G;
   logic [7:0] VGA_B;
   logic       VGA_HS;
   logic       VGA_VS;
   logic       VGA_BLANK_N;

   // Timing generator side: takes colour in, drives raster and VGA pins.
   modport master (
      input  Red_in, Green_in, Blue_in,
      output DrawX, DrawY, pixel_en, vblank_start,
      output VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_BLANK_N
   );

   // Consumer side: colour mapper / game logic / VGA pins.
   modport slave (
      output Red_in, Green_in, Blue_in,
      input  DrawX, DrawY, pixel_en, vblank_start,
      input  VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_BLANK_N
   );
endinterface
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_gen
// Description : 640x480@60 Hz raster timing. Pixel-rate divider, horizontal
//               and vertical counters, registered sync/blank/colour output
//               stage and a one-cycle vertical-blank frame tick.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_gen #(
   parameter int H_VISIBLE = 640,
   parameter int H_FRONT   = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BACK    = 48,
   parameter int V_VISIBLE = 480,
   parameter int V_FRONT   = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BACK    = 33,
   parameter int PIX_DIV   = 2
) (
   input  logic            Clk,
   input  logic            Reset,
   vga_timing_gen_if.master vga
);

   localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
   // A divide-by-one build still needs a one-bit divider register.
   localparam int DIV_W   = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

   localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(PIX_DIV - 1);
   localparam logic [9:0]       H_MAX    = 10'(H_TOTAL - 1);
   localparam logic [9:0]       V_MAX    = 10'(V_TOTAL - 1);
   localparam logic [9:0]       H_VIS    = 10'(H_VISIBLE);
   localparam logic [9:0]       V_VIS    = 10'(V_VISIBLE);
   localparam logic [9:0]       V_LAST   = 10'(V_VISIBLE - 1);
   localparam logic [9:0]       HS_BEG   = 10'(H_VISIBLE + H_FRONT);
   localparam logic [9:0]       HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
   localparam logic [9:0]       VS_BEG   = 10'(V_VISIBLE + V_FRONT);
   localparam logic [9:0]       VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

   logic [DIV_W-1:0] div;
   logic [9:0]       hc;
   logic [9:0]       vc;
   logic             pixel_en;
   logic             hs_c;
   logic             vs_c;
   logic             vis_c;
   logic [7:0]       red_q;
   logic [7:0]       green_q;
   logic [7:0]       blue_q;
   logic             hs_q;
   logic             vs_q;
   logic             blank_n_q;
   logic             vblank_q;

   // Strobe decoded straight from the divider register, no extra stage.
   assign pixel_en = (div == DIV_MAX);

   // Pixel-rate divider: counts 0..PIX_DIV-1 and wraps on the strobe.
   always_ff @(posedge Clk) begin
      if (Reset)
         div <= '0;
      else if (pixel_en)
         div <= '0;
      else
         div <= div + 1'b1;
   end

   // Raster counters: hc steps per pixel, vc steps when hc wraps.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         hc <= '0;
         vc <= '0;
      end else if (pixel_en) begin
         if (hc == H_MAX) begin
            hc <= '0;
            vc <= (vc == V_MAX) ? 10'd0 : vc + 10'd1;
         end else begin
            hc <= hc + 10'd1;
         end
      end
   end

   // Sync and visibility decodes of the current counter position.
   always_comb begin
      hs_c  = !((hc >= HS_BEG) && (hc < HS_END));
      vs_c  = !((vc >= VS_BEG) && (vc < VS_END));
      vis_c = (hc < H_VIS) && (vc < V_VIS);
   end

   // Output stage: sync, blank and colour share one register so they never skew.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         hs_q      <= 1'b1;
         vs_q      <= 1'b1;
         blank_n_q <= 1'b0;
         red_q     <= 8'd0;
         green_q   <= 8'd0;
         blue_q    <= 8'd0;
      end else if (pixel_en) begin
         hs_q      <= hs_c;
         vs_q      <= vs_c;
         blank_n_q <= vis_c;
         red_q     <= vis_c ? vga.Red_in   : 8'd0;
         green_q   <= vis_c ? vga.Green_in : 8'd0;
         blue_q    <= vis_c ? vga.Blue_in  : 8'd0;
      end
   end

   // Frame tick: set by the strobe that leaves the last visible line.
   always_ff @(posedge Clk) begin
      if (Reset)
         vblank_q <= 1'b0;
      else
         vblank_q <= pixel_en && (hc == H_MAX) && (vc == V_LAST);
   end

   assign vga.DrawX        = hc;
   assign vga.DrawY        = vc;
   assign vga.pixel_en     = pixel_en;
   assign vga.vblank_start = vblank_q;
   assign vga.VGA_R        = red_q;
   assign vga.VGA_G        = green_q;
   assign vga.VGA_B        = blue_q;
   assign vga.VGA_HS       = hs_q;
   assign vga.VGA_VS       = vs_q;
   assign vga.VGA_BLANK_N  = blank_n_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_timing_gen
// Description : Self-checking bench. Three generators (full 640x480 with
//               PIX_DIV=2, a miniature raster with PIX_DIV=2 and with
//               PIX_DIV=1) are compared every cycle against an arithmetic
//               model indexed by the number of cycles since reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;

   typedef struct packed {
      logic [9:0] hc;
      logic [9:0] vc;
      logic       pen;
      logic       vbs;
      logic       hs;
      logic       vs;
      logic       bl;
   } exp_t;

   logic       Clk = 1'b0;
   logic       Reset = 1'b1;
   logic [7:0] red = 8'h00;
   logic [7:0] green = 8'h00;
   logic [7:0] blue = 8'h00;

   int         t = 0;
   logic       valid = 1'b0;
   logic       run1 = 1'b0;
   logic       run2 = 1'b0;
   logic [23:0] cap_2 = '0;
   logic [23:0] cap_1 = '0;

   int checks = 0;
   int errors = 0;

   int hs_lo = 0, bl_hi = 0, r_aa = 0, r_bad = 0;
   int nb = 0, nc = 0;
   int tb1 = -1, tb2 = -1, tc1 = -1, tc2 = -1;

   vga_timing_gen_if vga_a ();
   vga_timing_gen_if vga_b ();
   vga_timing_gen_if vga_c ();

   assign vga_a.Red_in = red;  assign vga_a.Green_in = green;  assign vga_a.Blue_in = blue;
   assign vga_b.Red_in = red;  assign vga_b.Green_in = green;  assign vga_b.Blue_in = blue;
   assign vga_c.Red_in = red;  assign vga_c.Green_in = green;  assign vga_c.Blue_in = blue;

   vga_timing_gen #(.PIX_DIV(2)) dut_a (.Clk(Clk), .Reset(Reset), .vga(vga_a));

   vga_timing_gen #(
      .H_VISIBLE(16), .H_FRONT(4), .H_SYNC(6), .H_BACK(4),
      .V_VISIBLE(10), .V_FRONT(2), .V_SYNC(2), .V_BACK(3), .PIX_DIV(2)
   ) dut_b (.Clk(Clk), .Reset(Reset), .vga(vga_b));

   vga_timing_gen #(
      .H_VISIBLE(16), .H_FRONT(4), .H_SYNC(6), .H_BACK(4),
      .V_VISIBLE(10), .V_FRONT(2), .V_SYNC(2), .V_BACK(3), .PIX_DIV(1)
   ) dut_c (.Clk(Clk), .Reset(Reset), .vga(vga_c));

   always #10 Clk = ~Clk;

   // Expected outputs during cycle t after reset: t/d pixels have elapsed;
   // the VGA pins show the previous pixel.
   function automatic exp_t model(input int tt, input int d,
                                  input int hv, input int hf, input int hsw, input int hb,
                                  input int vv, input int vf, input int vsw, input int vb);
      int   ht = hv + hf + hsw + hb;
      int   vt = vv + vf + vsw + vb;
      int   p  = tt / d;
      int   q, h, v;
      exp_t e;
      e.hc  = 10'(p % ht);
      e.vc  = 10'((p / ht) % vt);
      e.pen = ((tt % d) == d - 1);
      e.vbs = ((tt % d) == 0) && (p >= 1) && ((p % (ht * vt)) == vv * ht);
      if (p == 0) begin
         e.hs = 1'b1; e.vs = 1'b1; e.bl = 1'b0;
      end else begin
         q = (p - 1) % (ht * vt);
         h = q % ht;
         v = q / ht;
         e.hs = !((h >= hv + hf) && (h < hv + hf + hsw));
         e.vs = !((v >= vv + vf) && (v < vv + vf + vsw));
         e.bl = (h < hv) && (v < vv);
      end
      return e;
   endfunction

   function automatic exp_t model_a(input int tt);
      return model(tt, 2, 640, 16, 96, 48, 480, 10, 2, 33);
   endfunction

   task automatic chk1(input string nm, input int act, input int exp_v);
      checks++;
      if (act != exp_v) begin
         errors++;
         if (errors <= 30)
            $display("FAIL %s at t=%0d: got %0h, expected %0h", nm, t, act, exp_v);
      end
   endtask

   task automatic chk_inst(input string nm, input exp_t e, input logic [23:0] cap,
                           input logic [9:0] dx, input logic [9:0] dy,
                           input logic pen, input logic vbs, input logic hs,
                           input logic vs, input logic bl,
                           input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
      logic [23:0] rgb;
      rgb = e.bl ? cap : 24'h0;
      chk1({nm, ".DrawX"}, int'(dx), int'(e.hc));
      chk1({nm, ".DrawY"}, int'(dy), int'(e.vc));
      chk1({nm, ".pixel_en"}, int'(pen), int'(e.pen));
      chk1({nm, ".vblank_start"}, int'(vbs), int'(e.vbs));
      chk1({nm, ".VGA_HS"}, int'(hs), int'(e.hs));
      chk1({nm, ".VGA_VS"}, int'(vs), int'(e.vs));
      chk1({nm, ".VGA_BLANK_N"}, int'(bl), int'(e.bl));
      chk1({nm, ".VGA_R"}, int'(r), int'(rgb[23:16]));
      chk1({nm, ".VGA_G"}, int'(g), int'(rgb[15:8]));
      chk1({nm, ".VGA_B"}, int'(b), int'(rgb[7:0]));
   endtask

   // Cycle index and the colour each build samples on its own strobes.
   always @(posedge Clk) begin
      if (Reset) begin
         t     <= 0;
         valid <= 1'b1;
      end else begin
         t     <= t + 1;
         cap_1 <= {red, green, blue};
         if ((t % 2) == 1)
            cap_2 <= {red, green, blue};
      end
   end

   // Single compare process: every cycle, all three builds against the model.
   always @(negedge Clk) begin
      if (valid) begin
         chk_inst("a", model_a(t), cap_2, vga_a.DrawX, vga_a.DrawY, vga_a.pixel_en,
                  vga_a.vblank_start, vga_a.VGA_HS, vga_a.VGA_VS, vga_a.VGA_BLANK_N,
                  vga_a.VGA_R, vga_a.VGA_G, vga_a.VGA_B);
         chk_inst("b", model(t, 2, 16, 4, 6, 4, 10, 2, 2, 3), cap_2, vga_b.DrawX,
                  vga_b.DrawY, vga_b.pixel_en, vga_b.vblank_start, vga_b.VGA_HS,
                  vga_b.VGA_VS, vga_b.VGA_BLANK_N, vga_b.VGA_R, vga_b.VGA_G, vga_b.VGA_B);
         chk_inst("c", model(t, 1, 16, 4, 6, 4, 10, 2, 2, 3), cap_1, vga_c.DrawX,
                  vga_c.DrawY, vga_c.pixel_en, vga_c.vblank_start, vga_c.VGA_HS,
                  vga_c.VGA_VS, vga_c.VGA_BLANK_N, vga_c.VGA_R, vga_c.VGA_G, vga_c.VGA_B);
         if (run1 && t < 1600) begin
            if (!vga_a.VGA_HS) hs_lo++;
            if (vga_a.VGA_BLANK_N) bl_hi++;
            if (vga_a.VGA_R == 8'hAA) r_aa++;
            if (!vga_a.VGA_BLANK_N && vga_a.VGA_R != 8'h00) r_bad++;
         end
         if (run2 && t < 2200) begin
            if (vga_b.vblank_start) begin
               nb++;
               if (tb1 < 0) tb1 = t; else if (tb2 < 0) tb2 = t;
            end
            if (vga_c.vblank_start) begin
               nc++;
               if (tc1 < 0) tc1 = t; else if (tc2 < 0) tc2 = t;
            end
         end
      end
   end

   initial begin
      exp_t e;
      bit   found;

      // Hand-computed points that pin the model itself.
      e = model_a(2);           chk1("model.first_pixel_hc", int'(e.hc), 1);
      e = model_a(1);           chk1("model.first_strobe", int'(e.pen), 1);
      e = model_a(2 * 656);     chk1("model.hs_before", int'(e.hs), 1);
      e = model_a(2 * 657);     chk1("model.hs_first_low", int'(e.hs), 0);
      e = model_a(2 * 752);     chk1("model.hs_last_low", int'(e.hs), 0);
      e = model_a(2 * 753);     chk1("model.hs_after", int'(e.hs), 1);
      e = model_a(2 * 640);     chk1("model.last_visible", int'(e.bl), 1);
      e = model_a(2 * 641);     chk1("model.first_blank", int'(e.bl), 0);
      e = model_a(2 * 384000);  chk1("model.vblank_at_480", int'(e.vbs), 1);
      chk1("model.vblank_vc", int'(e.vc), 480);
      e = model_a(840000);      chk1("model.frame_wrap", int'({e.hc, e.vc}), 0);
      e = model_a(2 * 80900);   chk1("model.line_wrap_vc", int'(e.vc), 101);

      // Reset then release; first run of one full default line.
      red = 8'hAA; green = 8'h55; blue = 8'h0F;
      repeat (3) @(posedge Clk);
      #1 Reset = 1'b0;
      run1 = 1'b1;
      repeat (1700) @(posedge Clk);
      #1 red = 8'hC3; green = 8'h3C; blue = 8'hF0;
      repeat (300) @(posedge Clk);
      #1 red = 8'h00; green = 8'h00; blue = 8'h00;
      run1 = 1'b0;

      chk1("line.hs_low_cycles", hs_lo, 2 * 96);
      chk1("line.blank_n_high_cycles", bl_hi, 2 * 640);
      chk1("line.red_aa_cycles", r_aa, 2 * 640);
      chk1("line.red_in_blank", r_bad, 0);

      // One-cycle reset in mid-frame on the miniature raster.
      found = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge Clk);
         if (vga_b.DrawX == 10'd20 && vga_b.DrawY == 10'd5) begin
            found = 1'b1;
            break;
         end
      end
      chk1("mid_reset.reached", int'(found), 1);
      Reset = 1'b1;
      @(posedge Clk);
      #1 Reset = 1'b0;
      run2 = 1'b1;
      red = 8'hFF; green = 8'hFF; blue = 8'hFF;
      repeat (700) @(posedge Clk);
      #1 red = 8'h12; green = 8'h34; blue = 8'h56;
      repeat (700) @(posedge Clk);
      #1 red = 8'hAA; green = 8'h55; blue = 8'h0F;
      repeat (850) @(posedge Clk);

      chk1("frame.b_vblank_count", nb, 2);
      chk1("frame.b_first_vblank", tb1, 600);
      chk1("frame.b_period", tb2 - tb1, 1020);
      chk1("frame.c_vblank_count", nc, 4);
      chk1("frame.c_first_vblank", tc1, 300);
      chk1("frame.c_period", tc2 - tc1, 510);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
